// File: rtl/corr_stream_pkg.sv
// corr_stream_pkg: shared FSM encoding, word order and header tag for the correlator result streamer
package corr_stream_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_AA, ST_BB, ST_RE, ST_IM} state_t;
   localparam int W_AA = 0;
   localparam int W_BB = 1;
   localparam int W_RE = 2;
   localparam int W_IM = 3;
   localparam int N_WORDS = 4;
   localparam logic [7:0] HDR_TAG = 8'hC0;
   function automatic int frame_w(input int din_width);
      return N_WORDS * din_width;
   endfunction
endpackage

// File: rtl/corr_frame_fifo.sv
// corr_frame_fifo: synchronous frame FIFO with registered read data, count, full and empty
module corr_frame_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         rd_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/corr_result_streamer.sv
// corr_result_streamer: buffers correlator result frames and streams each as an AXI-Stream packet; CORR_STREAM_SEQ_HEADER_EN prefixes a sequence header word
module corr_result_streamer
   import corr_stream_pkg::*;
#(
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIN_WIDTH-1:0]  aa,
   input  logic [DIN_WIDTH-1:0]  bb,
   input  logic [DIN_WIDTH-1:0]  ab_re,
   input  logic [DIN_WIDTH-1:0]  ab_im,
   input  logic                  din_valid,
   output logic [DOUT_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  overflow,
   output logic [CNT_WIDTH-1:0]  drop_count
);
   localparam int FRAME_W = frame_w(DIN_WIDTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state, state_nx;
   logic [FRAME_W-1:0] rd_data, frm;
   logic [CW-1:0] fifo_count;
   logic [CW:0] occ;
   logic fifo_full, fifo_empty, pre_valid, accept, pop, load, hs, last_hs;
   logic [DOUT_WIDTH-1:0] w_aa, w_bb, w_re, w_im, w_hdr;

   corr_frame_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(accept),
      .wr_data({ab_im, ab_re, bb, aa}),
      .pop(pop),
      .rd_data(rd_data),
      .count(fifo_count),
      .full(fifo_full),
      .empty(fifo_empty)
   );

   // A frame counts against FIFO_DEPTH from acceptance until its last word is taken
   assign occ = (CW+1)'(fifo_count) + (CW+1)'(pre_valid) + (CW+1)'(state != ST_IDLE);
   assign accept = din_valid && !fifo_full && occ < (CW+1)'(FIFO_DEPTH);
   assign hs = m_axis_tvalid && m_axis_tready;
   assign last_hs = hs && state == ST_IM;
   assign load = pre_valid && (state == ST_IDLE || last_hs);
   assign pop = !fifo_empty && (!pre_valid || load);

`ifdef CORR_STREAM_SEQ_HEADER_EN
   localparam state_t FIRST = ST_HDR;
   logic [CNT_WIDTH-1:0] seq;
   assign w_hdr = {HDR_TAG, {(DOUT_WIDTH-8-CNT_WIDTH){1'b0}}, seq};
   always_ff @(posedge clk) seq <= rst ? '0 : seq + CNT_WIDTH'(last_hs);
`else
   localparam state_t FIRST = ST_AA;
   assign w_hdr = '0;
`endif

   assign w_aa = DOUT_WIDTH'(frm[W_AA*DIN_WIDTH +: DIN_WIDTH]);
   assign w_bb = DOUT_WIDTH'(frm[W_BB*DIN_WIDTH +: DIN_WIDTH]);
   assign w_re = DOUT_WIDTH'($signed(frm[W_RE*DIN_WIDTH +: DIN_WIDTH]));
   assign w_im = DOUT_WIDTH'($signed(frm[W_IM*DIN_WIDTH +: DIN_WIDTH]));
   assign m_axis_tvalid = state != ST_IDLE;
   assign m_axis_tlast = state == ST_IM;
   assign m_axis_tdata = state == ST_HDR ? w_hdr : state == ST_AA ? w_aa : state == ST_BB ? w_bb :
                         state == ST_RE ? w_re : state == ST_IM ? w_im : '0;

   always_comb state_nx = load ? FIRST : last_hs ? ST_IDLE : hs ? state_t'(state + 3'd1) : state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         frm <= '0;
         pre_valid <= 1'b0;
         overflow <= 1'b0;
         drop_count <= '0;
      end else begin
         state <= state_nx;
         pre_valid <= pop || (pre_valid && !load);
         if (load) frm <= rd_data;
         if (din_valid && !accept) begin
            overflow <= 1'b1;
            drop_count <= drop_count + CNT_WIDTH'(!(&drop_count));
         end
      end
   end
endmodule

// File: tb/tb_corr_result_streamer.sv
// tb_corr_result_streamer: randomized and directed checks of corr_result_streamer against a frame-queue model
module tb_corr_result_streamer;
`ifdef CORR_STREAM_SEQ_HEADER_EN
   localparam int LEN = 5;
`else
   localparam int LEN = 4;
`endif
   localparam int HOFS = LEN - 4;
   localparam int DEPTH = 8;
   localparam int SAT = 15;

   typedef struct {
      logic [23:0] aa, bb, re, im;
      int seq;
      int t;
   } frame_t;

   logic clk, rst, din_valid, m_axis_tready, m_axis_tvalid, m_axis_tlast, overflow;
   logic [23:0] aa, bb, ab_re, ab_im;
   logic [31:0] m_axis_tdata;
   logic [3:0] drop_count;

   int checks = 0, failures = 0, cyc = 0, nw = 0, nl = 0;
   bit chk_en = 0;
   frame_t q[$];
   frame_t cur, nf;
   bit busy = 0, m_ovf = 0, m_fin;
   int widx = 0, m_acc = 0, m_drop = 0, m_occ;

   corr_result_streamer #(.DIN_WIDTH(24), .DOUT_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .aa(aa), .bb(bb), .ab_re(ab_re), .ab_im(ab_im), .din_valid(din_valid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .overflow(overflow), .drop_count(drop_count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input frame_t f, input int idx);
      int k;
      k = idx - HOFS;
      if (k < 0) return 32'hC000_0000 | 32'(f.seq);
      if (k == 0) return {8'h00, f.aa};
      if (k == 1) return {8'h00, f.bb};
      if (k == 2) return {{8{f.re[23]}}, f.re};
      return {{8{f.im[23]}}, f.im};
   endfunction

   // Frame-level model: frames queue on acceptance, each streams no earlier than two edges later
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         busy = 0;
         widx = 0;
         m_acc = 0;
         m_ovf = 0;
         m_drop = 0;
      end else begin
         m_occ = q.size() + (busy ? 1 : 0);
         m_fin = busy && m_axis_tready && widx == LEN - 1;
         if (busy && m_axis_tready) widx++;
         if (m_fin) busy = 0;
         if (!busy && q.size() > 0 && q[0].t + 2 <= cyc) begin
            cur = q.pop_front();
            busy = 1;
            widx = 0;
         end
         if (din_valid) begin
            if (m_occ < DEPTH) begin
               nf.aa = aa; nf.bb = bb; nf.re = ab_re; nf.im = ab_im; nf.seq = m_acc; nf.t = cyc;
               q.push_back(nf);
               m_acc = (m_acc + 1) % 16;
            end else begin
               m_ovf = 1;
               if (m_drop < SAT) m_drop++;
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) if (chk_en) begin
      chk("tvalid", 64'(m_axis_tvalid), 64'(busy));
      chk("tlast", 64'(m_axis_tlast), 64'(busy && widx == LEN - 1));
      if (busy) chk("tdata", 64'(m_axis_tdata), 64'(exp_word(cur, widx)));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
   end

   always @(negedge clk) if (m_axis_tvalid && m_axis_tready) begin
      nw++;
      if (m_axis_tlast) nl++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic [23:0] a, input logic [23:0] b, input logic [23:0] r, input logic [23:0] i);
      aa = a; bb = b; ab_re = r; ab_im = i; din_valid = 1;
      tick();
      din_valid = 0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      m_axis_tready = 1;
      while ((busy || q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_budget", 64'(n < budget), 64'd1);
      tick();
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      logic [31:0] w1 [5];
      rst = 1; din_valid = 0; m_axis_tready = 0; aa = 0; bb = 0; ab_re = 0; ab_im = 0;
      repeat (3) tick();
      rst = 0;
      chk_en = 1;
      @(negedge clk);
      chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
      chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
      chk("reset_drop", 64'(drop_count), 64'd0);

      m_axis_tready = 1;
      if (HOFS == 1) begin
         w1[0] = 32'hC000_0000; w1[1] = 32'd1; w1[2] = 32'd2; w1[3] = 32'hFFFF_FFFD; w1[4] = 32'd4;
      end else begin
         w1[0] = 32'd1; w1[1] = 32'd2; w1[2] = 32'hFFFF_FFFD; w1[3] = 32'd4; w1[4] = 32'd0;
      end
      pulse(24'd1, 24'd2, -24'sd3, 24'd4);
      @(negedge clk); chk("single_lat_n", 64'(m_axis_tvalid), 64'd0);
      @(negedge clk); chk("single_lat_n1", 64'(m_axis_tvalid), 64'd0);
      for (int i = 0; i < LEN; i++) begin
         @(negedge clk);
         chk("single_tvalid", 64'(m_axis_tvalid), 64'd1);
         chk("single_tdata", 64'(m_axis_tdata), 64'(w1[i]));
         chk("single_tlast", 64'(m_axis_tlast), 64'(i == LEN - 1));
      end
      @(negedge clk);
      chk("single_overflow", 64'(overflow), 64'd0);
      chk("single_done", 64'(m_axis_tvalid), 64'd0);

      tick();
      m_axis_tready = 0;
      pulse(24'hABCDEF, 24'h123456, 24'h800000, 24'h7FFFFF);
      tick(); tick();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
         chk("stall_tdata", 64'(m_axis_tdata), HOFS == 1 ? 64'h0000_0000_C000_0001 : 64'h0000_0000_00AB_CDEF);
      end
      drain(50);

      m_axis_tready = 0;
      for (int i = 0; i < 10; i++) pulse(24'(i), 24'(i + 100), 24'(-i), 24'(i * 3));
      @(negedge clk);
      chk("ovf_drop_count", 64'(drop_count), 64'd2);
      chk("ovf_overflow", 64'(overflow), 64'd1);
      tick();
      nw = 0; nl = 0;
      drain(200);
      chk("ovf_words", 64'(nw), 64'(8 * LEN));
      chk("ovf_packets", 64'(nl), 64'd8);

      m_axis_tready = 0;
      for (int i = 0; i < 8; i++) pulse(24'(i + 7), 24'(i), 24'(i), 24'(i));
      tick();
      m_axis_tready = 1;
      repeat (LEN - 1) tick();
      din_valid = 1;
      tick();
      din_valid = 0;
      m_axis_tready = 0;
      @(negedge clk);
      chk("pop_push_drop", 64'(drop_count), 64'd3);
      pulse(24'h55, 24'h66, 24'h77, 24'h88);
      @(negedge clk);
      chk("pop_push_after", 64'(drop_count), 64'd3);
      drain(200);

      pulse(24'h10, 24'h20, 24'h30, 24'h40);
      repeat (5) tick();
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("midrst_drop", 64'(drop_count), 64'd0);
      chk("midrst_overflow", 64'(overflow), 64'd0);
      pulse(24'h31, 24'h32, 24'h33, 24'h34);
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("midrst_first", 64'(m_axis_tdata), HOFS == 1 ? 64'h0000_0000_C000_0000 : 64'h31);
      drain(50);

      for (int p = 0; p < 8; p++) begin
         for (int c = 0; c < 100; c++) begin
            din_valid = $urandom_range(0, 99) < 35;
            m_axis_tready = $urandom_range(0, 99) < ((p % 2 == 0) ? 90 : 15);
            aa = 24'($urandom); bb = 24'($urandom); ab_re = 24'($urandom); ab_im = 24'($urandom);
            tick();
         end
      end
      din_valid = 0;
      drain(500);

      do_reset();
      m_axis_tready = 0;
      for (int i = 0; i < 25; i++) pulse(24'($urandom), 24'(i), 24'(i), 24'(i));
      @(negedge clk);
      chk("sat_drop", 64'(drop_count), 64'd15);
      chk("sat_overflow", 64'(overflow), 64'd1);
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end
endmodule
